// File: rtl/mips_defs.sv
// Shared MIPS32 pipeline definitions: control-field widths, RegDst encodings,
// the $ra register number and the ID/EX pipeline register layout.
package mips_defs;

    localparam int XLEN       = 32;
    localparam int REG_W      = 5;
    localparam int FUNCT_W    = 6;
    localparam int PCSRC_W    = 2;
    localparam int REGDST_W   = 2;
    localparam int MEMTOREG_W = 2;
    localparam int ALUOP_W    = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    typedef enum logic [REGDST_W-1:0] {
        RD_RT   = 2'b00,
        RD_RD   = 2'b01,
        RD_RA   = 2'b10,
        RD_DUAL = 2'b11
    } regdst_e;

    typedef struct packed {
        logic                  valid;
        logic [PCSRC_W-1:0]    pcsrc;
        logic                  branch;
        logic                  regwrite;
        logic                  regwrite2;
        logic                  memread;
        logic                  memwrite;
        logic [MEMTOREG_W-1:0] memtoreg;
        logic                  alusrc1;
        logic                  alusrc2;
        logic                  luop;
        logic [ALUOP_W-1:0]    aluop;
        logic [XLEN-1:0]       pc_plus4;
        logic [XLEN-1:0]       rs_data;
        logic [XLEN-1:0]       rt_data;
        logic [XLEN-1:0]       imm_ext;
        logic [REG_W-1:0]      rs;
        logic [REG_W-1:0]      rt;
        logic [REG_W-1:0]      shamt;
        logic [FUNCT_W-1:0]    funct;
        logic [REG_W-1:0]      wr_reg;
        logic [REG_W-1:0]      wr_reg2;
    } id_ex_t;

    // Dual-write instructions (RD_DUAL) put their primary result in rd; rt is
    // always carried separately as the secondary destination.
    function automatic logic [REG_W-1:0] resolve_dest(
        input regdst_e          sel,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd
    );
        logic [REG_W-1:0] dest;
        case (sel)
            RD_RT:   dest = rt;
            RD_RD:   dest = rd;
            RD_RA:   dest = REG_RA;
            RD_DUAL: dest = rd;
            default: dest = rt;
        endcase
        return dest;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: flags an ID instruction that reads
// the register being loaded by the valid load currently in EX.
module hazard_detect
    import mips_defs::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_wr_reg2,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    output logic             hz
);

    logic load_in_ex_s;
    logic rs_match_s;
    logic rt_match_s;

    // $zero is never a real dependency, so loads into it cannot stall.
    always_comb begin
        load_in_ex_s = ex_valid & ex_mem_read & (ex_wr_reg2 != REG_ZERO);
        rs_match_s   = id_uses_rs & (id_rs == ex_wr_reg2);
        rt_match_s   = id_uses_rt & (id_rt == ex_wr_reg2);
        hz           = load_in_ex_s & (rs_match_s | rt_match_s);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded control bundle and operands,
// resolves destinations, inserts load-use bubbles and counts them.
module id_ex_stage
    import mips_defs::*;
#(
    parameter int W_CNT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PCSRC_W-1:0]    id_PCSrc,
    input  logic                  id_Branch,
    input  logic                  id_RegWrite,
    input  logic                  id_RegWrite2,
    input  logic [REGDST_W-1:0]   id_RegDst,
    input  logic                  id_MemRead,
    input  logic                  id_MemWrite,
    input  logic [MEMTOREG_W-1:0] id_MemtoReg,
    input  logic                  id_ALUSrc1,
    input  logic                  id_ALUSrc2,
    input  logic                  id_LuOp,
    input  logic [ALUOP_W-1:0]    id_ALUOp,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc_plus4,
    input  logic [XLEN-1:0]       id_rs_data,
    input  logic [XLEN-1:0]       id_rt_data,
    input  logic [XLEN-1:0]       id_imm_ext,
    input  logic [REG_W-1:0]      id_rs,
    input  logic [REG_W-1:0]      id_rt,
    input  logic [REG_W-1:0]      id_rd,
    input  logic [REG_W-1:0]      id_shamt,
    input  logic [FUNCT_W-1:0]    id_funct,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_flush,
    input  logic                  ex_hold,
    output logic [PCSRC_W-1:0]    ex_PCSrc,
    output logic                  ex_Branch,
    output logic                  ex_RegWrite,
    output logic                  ex_RegWrite2,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic [MEMTOREG_W-1:0] ex_MemtoReg,
    output logic                  ex_ALUSrc1,
    output logic                  ex_ALUSrc2,
    output logic                  ex_LuOp,
    output logic [ALUOP_W-1:0]    ex_ALUOp,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc_plus4,
    output logic [XLEN-1:0]       ex_rs_data,
    output logic [XLEN-1:0]       ex_rt_data,
    output logic [XLEN-1:0]       ex_imm_ext,
    output logic [REG_W-1:0]      ex_rs,
    output logic [REG_W-1:0]      ex_rt,
    output logic [REG_W-1:0]      ex_shamt,
    output logic [FUNCT_W-1:0]    ex_funct,
    output logic [REG_W-1:0]      ex_wr_reg,
    output logic [REG_W-1:0]      ex_wr_reg2,
    output logic                  id_stall,
    output logic [W_CNT-1:0]      bubble_count
);

    localparam logic [W_CNT-1:0] CNT_MAX = {W_CNT{1'b1}};

    id_ex_t           ex_r;
    id_ex_t           load_s;
    logic [W_CNT-1:0] cnt_r;
    logic             hz_s;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_r.valid),
        .ex_mem_read (ex_r.memread),
        .ex_wr_reg2  (ex_r.wr_reg2),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .hz          (hz_s)
    );

    // Next-value of the register on a normal load; enables are squashed for empty slots.
    always_comb begin
        load_s          = '0;
        load_s.valid    = id_valid;
        load_s.memtoreg = id_MemtoReg;
        load_s.alusrc1  = id_ALUSrc1;
        load_s.alusrc2  = id_ALUSrc2;
        load_s.luop     = id_LuOp;
        load_s.aluop    = id_ALUOp;
        load_s.pc_plus4 = id_pc_plus4;
        load_s.rs_data  = id_rs_data;
        load_s.rt_data  = id_rt_data;
        load_s.imm_ext  = id_imm_ext;
        load_s.rs       = id_rs;
        load_s.rt       = id_rt;
        load_s.shamt    = id_shamt;
        load_s.funct    = id_funct;
        load_s.wr_reg   = resolve_dest(regdst_e'(id_RegDst), id_rt, id_rd);
        load_s.wr_reg2  = id_rt;
        if (id_valid) begin
            load_s.pcsrc     = id_PCSrc;
            load_s.branch    = id_Branch;
            load_s.regwrite  = id_RegWrite;
            load_s.regwrite2 = id_RegWrite2;
            load_s.memread   = id_MemRead;
            load_s.memwrite  = id_MemWrite;
        end else begin
            load_s.pcsrc     = {PCSRC_W{1'b0}};
            load_s.branch    = 1'b0;
            load_s.regwrite  = 1'b0;
            load_s.regwrite2 = 1'b0;
            load_s.memread   = 1'b0;
            load_s.memwrite  = 1'b0;
        end
    end

    // Pipeline register update: reset > flush > hold > bubble > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r  <= '0;
            cnt_r <= '0;
        end else if (ex_flush) begin
            ex_r  <= '0;
        end else if (ex_hold) begin
            ex_r  <= ex_r;
        end else if (hz_s) begin
            ex_r  <= '0;
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + W_CNT'(1'b1);
            end
        end else begin
            ex_r  <= load_s;
        end
    end

    // A flush already kills the ID instruction, so it must not also stall it.
    assign id_stall = (hz_s & ~ex_flush) | ex_hold;

    assign ex_PCSrc     = ex_r.pcsrc;
    assign ex_Branch    = ex_r.branch;
    assign ex_RegWrite  = ex_r.regwrite;
    assign ex_RegWrite2 = ex_r.regwrite2;
    assign ex_MemRead   = ex_r.memread;
    assign ex_MemWrite  = ex_r.memwrite;
    assign ex_MemtoReg  = ex_r.memtoreg;
    assign ex_ALUSrc1   = ex_r.alusrc1;
    assign ex_ALUSrc2   = ex_r.alusrc2;
    assign ex_LuOp      = ex_r.luop;
    assign ex_ALUOp     = ex_r.aluop;
    assign ex_valid     = ex_r.valid;
    assign ex_pc_plus4  = ex_r.pc_plus4;
    assign ex_rs_data   = ex_r.rs_data;
    assign ex_rt_data   = ex_r.rt_data;
    assign ex_imm_ext   = ex_r.imm_ext;
    assign ex_rs        = ex_r.rs;
    assign ex_rt        = ex_r.rt;
    assign ex_shamt     = ex_r.shamt;
    assign ex_funct     = ex_r.funct;
    assign ex_wr_reg    = ex_r.wr_reg;
    assign ex_wr_reg2   = ex_r.wr_reg2;
    assign bubble_count = cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/hold/dest/saturation
// scenarios followed by random traffic, all against a behavioural model.
module tb_id_ex_stage;

    localparam int W   = 3;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] id_PCSrc, id_RegDst, id_MemtoReg;
    logic id_Branch, id_RegWrite, id_RegWrite2, id_MemRead, id_MemWrite;
    logic id_ALUSrc1, id_ALUSrc2, id_LuOp, id_valid, id_uses_rs, id_uses_rt;
    logic [3:0] id_ALUOp;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0] id_rs, id_rt, id_rd, id_shamt;
    logic [5:0] id_funct;
    logic ex_flush, ex_hold;

    logic [1:0] ex_PCSrc, ex_MemtoReg;
    logic ex_Branch, ex_RegWrite, ex_RegWrite2, ex_MemRead, ex_MemWrite;
    logic ex_ALUSrc1, ex_ALUSrc2, ex_LuOp, ex_valid, id_stall;
    logic [3:0] ex_ALUOp;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0] ex_rs, ex_rt, ex_shamt, ex_wr_reg, ex_wr_reg2;
    logic [5:0] ex_funct;
    logic [W-1:0] bubble_count;

    id_ex_stage #(.W_CNT(W)) dut (
        .clk(clk), .reset(reset),
        .id_PCSrc(id_PCSrc), .id_Branch(id_Branch), .id_RegWrite(id_RegWrite),
        .id_RegWrite2(id_RegWrite2), .id_RegDst(id_RegDst), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_ALUSrc1(id_ALUSrc1),
        .id_ALUSrc2(id_ALUSrc2), .id_LuOp(id_LuOp), .id_ALUOp(id_ALUOp), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_flush(ex_flush), .ex_hold(ex_hold),
        .ex_PCSrc(ex_PCSrc), .ex_Branch(ex_Branch), .ex_RegWrite(ex_RegWrite),
        .ex_RegWrite2(ex_RegWrite2), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2),
        .ex_LuOp(ex_LuOp), .ex_ALUOp(ex_ALUOp), .ex_valid(ex_valid),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_shamt(ex_shamt),
        .ex_funct(ex_funct), .ex_wr_reg(ex_wr_reg), .ex_wr_reg2(ex_wr_reg2),
        .id_stall(id_stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // Expected EX-side contents, ordered to match the obs() concatenation.
    typedef struct packed {
        logic [1:0]  pcsrc;
        logic        branch, regwrite, regwrite2, memread, memwrite;
        logic [1:0]  memtoreg;
        logic        alusrc1, alusrc2, luop;
        logic [3:0]  aluop;
        logic        valid;
        logic [31:0] pc_plus4, rs_data, rt_data, imm_ext;
        logic [4:0]  rs, rt, shamt;
        logic [5:0]  funct;
        logic [4:0]  wr_reg, wr_reg2;
    } exp_t;

    exp_t m = '0;
    int   m_cnt = 0;
    logic m_known = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [175:0] obs();
        return {ex_PCSrc, ex_Branch, ex_RegWrite, ex_RegWrite2, ex_MemRead, ex_MemWrite,
                ex_MemtoReg, ex_ALUSrc1, ex_ALUSrc2, ex_LuOp, ex_ALUOp, ex_valid,
                ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_shamt,
                ex_funct, ex_wr_reg, ex_wr_reg2};
    endfunction

    task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Does the ID instruction read the register that a real load in EX is fetching?
    function automatic logic model_hz();
        logic reads_it;
        reads_it = (id_uses_rs && id_rs == m.wr_reg2) || (id_uses_rt && id_rt == m.wr_reg2);
        return m.valid && m.memread && (m.wr_reg2 != 5'd0) && reads_it;
    endfunction

    task automatic model_edge(input logic hz);
        logic [4:0] dest_tbl [4];
        dest_tbl = '{id_rt, id_rd, 5'd31, id_rd};
        if (reset) begin
            m = '0;
            m_cnt = 0;
        end else if (ex_flush) begin
            m = '0;
        end else if (ex_hold) begin
            m = m;
        end else if (hz) begin
            m = '0;
            m_cnt = (m_cnt < MAX) ? m_cnt + 1 : MAX;
        end else begin
            m.valid     = id_valid;
            m.pcsrc     = id_valid ? id_PCSrc : 2'd0;
            m.branch    = id_valid & id_Branch;
            m.regwrite  = id_valid & id_RegWrite;
            m.regwrite2 = id_valid & id_RegWrite2;
            m.memread   = id_valid & id_MemRead;
            m.memwrite  = id_valid & id_MemWrite;
            m.memtoreg  = id_MemtoReg;
            m.alusrc1   = id_ALUSrc1;
            m.alusrc2   = id_ALUSrc2;
            m.luop      = id_LuOp;
            m.aluop     = id_ALUOp;
            m.pc_plus4  = id_pc_plus4;
            m.rs_data   = id_rs_data;
            m.rt_data   = id_rt_data;
            m.imm_ext   = id_imm_ext;
            m.rs        = id_rs;
            m.rt        = id_rt;
            m.shamt     = id_shamt;
            m.funct     = id_funct;
            m.wr_reg    = dest_tbl[id_RegDst];
            m.wr_reg2   = id_rt;
        end
    endtask

    // One clock: check the combinational stall, clock, then check registered state.
    task automatic step(input string tag);
        logic hz;
        #1;
        hz = model_hz();
        if (m_known) chk({tag, ":stall"}, id_stall, (hz && !ex_flush) || ex_hold);
        @(posedge clk);
        model_edge(hz);
        m_known = 1'b1;
        #1;
        chk({tag, ":ex"}, obs(), m);
        chk({tag, ":cnt"}, bubble_count, m_cnt);
    endtask

    task automatic rand_inputs(input logic narrow);
        id_PCSrc = 2'($urandom);      id_Branch = 1'($urandom);
        id_RegWrite = 1'($urandom);   id_RegWrite2 = 1'($urandom);
        id_RegDst = 2'($urandom);     id_MemRead = 1'($urandom);
        id_MemWrite = 1'($urandom);   id_MemtoReg = 2'($urandom);
        id_ALUSrc1 = 1'($urandom);    id_ALUSrc2 = 1'($urandom);
        id_LuOp = 1'($urandom);       id_ALUOp = 4'($urandom);
        id_valid = 1'($urandom);      id_pc_plus4 = $urandom;
        id_rs_data = $urandom;        id_rt_data = $urandom;
        id_imm_ext = $urandom;        id_shamt = 5'($urandom);
        id_funct = 6'($urandom);      id_rd = 5'($urandom);
        id_uses_rs = 1'($urandom);    id_uses_rt = 1'($urandom);
        id_rs = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        id_rt = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
    endtask

    task automatic instr(input logic memread, input logic [1:0] regdst, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic urs,
                         input logic urt);
        rand_inputs(1'b0);
        id_valid = 1'b1;  id_RegWrite = 1'b1;  id_MemRead = memread;
        id_RegDst = regdst;  id_rs = rs;  id_rt = rt;  id_rd = rd;
        id_uses_rs = urs;  id_uses_rt = urt;
    endtask

    initial begin
        logic [4:0] dest_exp [4];
        dest_exp = '{5'd5, 5'd9, 5'd31, 5'd9};

        // Reset for two cycles with random inputs.
        reset = 1'b1;  ex_hold = 1'b0;
        rand_inputs(1'b0);  ex_flush = 1'($urandom);
        step("rst0");
        rand_inputs(1'b0);  ex_flush = 1'($urandom);
        step("rst1");
        chk("rst_zero", obs(), 176'd0);
        chk("rst_stall", id_stall, 1'b0);
        chk("rst_cnt", bubble_count, 3'd0);
        reset = 1'b0;  ex_flush = 1'b0;

        // lw $t0 then dependent add: one stall, one bubble, then add loads.
        instr(1'b1, 2'b00, 5'd29, 5'd8, 5'd0, 1'b1, 1'b0);
        step("lw");
        chk("lw_wr2", ex_wr_reg2, 5'd8);
        instr(1'b0, 2'b01, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1);
        #1 chk("lu_stall", id_stall, 1'b1);
        step("lu_bubble");
        chk("lu_bub_valid", ex_valid, 1'b0);
        chk("lu_bub_rw", ex_RegWrite, 1'b0);
        chk("lu_bub_cnt", bubble_count, 3'd1);
        step("lu_add");
        chk("lu_add_dst", ex_wr_reg, 5'd10);
        chk("lu_add_valid", ex_valid, 1'b1);

        // Load into $zero never stalls.
        instr(1'b1, 2'b00, 5'd29, 5'd0, 5'd0, 1'b1, 1'b0);
        step("lw_zero");
        instr(1'b0, 2'b01, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
        #1 chk("zero_stall", id_stall, 1'b0);
        step("after_zero");

        // Flush overrides a pending hazard: no stall, no bubble counted.
        instr(1'b1, 2'b00, 5'd29, 5'd8, 5'd0, 1'b1, 1'b0);
        step("lw_fl");
        instr(1'b0, 2'b01, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0);
        ex_flush = 1'b1;
        #1 chk("fl_stall", id_stall, 1'b0);
        step("flush");
        chk("fl_valid", ex_valid, 1'b0);
        chk("fl_cnt", bubble_count, 3'd1);
        ex_flush = 1'b0;

        // Hold freezes the register for three cycles while ID changes.
        instr(1'b1, 2'b00, 5'd29, 5'd8, 5'd0, 1'b0, 1'b0);
        step("lw_hold");
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1'b0);
            #1 chk("hold_stall", id_stall, 1'b1);
            step("hold");
            chk("hold_wr2", ex_wr_reg2, 5'd8);
        end
        ex_hold = 1'b0;
        instr(1'b0, 2'b01, 5'd3, 5'd4, 5'd17, 1'b0, 1'b0);
        step("release");
        chk("rel_dst", ex_wr_reg, 5'd17);
        chk("rel_valid", ex_valid, 1'b1);

        // Destination resolution sweep.
        for (int i = 0; i < 4; i++) begin
            instr(1'b0, 2'(i), 5'd3, 5'd5, 5'd9, 1'b0, 1'b0);
            step("dest");
            chk("dest_wr", ex_wr_reg, dest_exp[i]);
            chk("dest_wr2", ex_wr_reg2, 5'd5);
        end

        // Nine bubbles from a self-dependent load chain saturate the 3-bit counter.
        reset = 1'b1;
        step("sat_rst");
        reset = 1'b0;
        instr(1'b1, 2'b00, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) step("sat");
        chk("sat_cnt", bubble_count, 3'd7);

        // Random traffic with occasional flush, hold and reset.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            ex_flush = ($urandom_range(0, 7) == 0);
            ex_hold  = ($urandom_range(0, 5) == 0);
            reset    = ($urandom_range(0, 63) == 0);
            step("rand");
        end

        // Reset mid-stall clears in one cycle.
        reset = 1'b0;  ex_flush = 1'b0;  ex_hold = 1'b0;
        instr(1'b1, 2'b00, 5'd29, 5'd8, 5'd0, 1'b0, 1'b0);
        step("lw_end");
        instr(1'b0, 2'b01, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0);
        reset = 1'b1;
        step("end_rst");
        chk("end_zero", obs(), 176'd0);
        chk("end_stall", id_stall, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Sits between the instruction decoder and the execute stage of the 5-stage MIPS32 pipeline. Registers the decoder's control bundle together with the ID-stage operand data, and resolves the destination register. Detects load-use hazards against the instruction already in EX, inserts bubbles, and honours flush and hold requests. Also maintains a saturating bubble counter for performance monitoring.

## Interface
- `W_CNT`, default 32: width of the bubble counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `id_PCSrc` in 2, `id_Branch` in 1, `id_RegWrite` in 1, `id_RegWrite2` in 1: decoder control fields.
- `id_RegDst` in 2, `id_MemRead` in 1, `id_MemWrite` in 1, `id_MemtoReg` in 2: decoder control fields.
- `id_ALUSrc1` in 1, `id_ALUSrc2` in 1, `id_LuOp` in 1, `id_ALUOp` in 4: decoder control fields.
- `id_valid` in 1: the IF/ID slot holds a real instruction.
- `id_pc_plus4` in 32, `id_rs_data` in 32, `id_rt_data` in 32, `id_imm_ext` in 32: operands and the extended immediate.
- `id_rs` in 5, `id_rt` in 5, `id_rd` in 5, `id_shamt` in 5, `id_funct` in 6: instruction fields.
- `id_uses_rs` in 1, `id_uses_rt` in 1: the ID instruction actually reads that register.
- `ex_flush` in 1: branch taken or jump resolved; kill the ID instruction.
- `ex_hold` in 1: a downstream stage is stalled; freeze this register.
- `ex_*` out: registered copies of every `id_*` control and data field above except `id_RegDst`, `id_uses_*` and `id_rd`.
- `ex_valid` out 1: registered copy of the slot-valid flag.
- `ex_wr_reg` out 5: resolved primary destination register.
- `ex_wr_reg2` out 5: secondary destination register.
- `id_stall` out 1: freeze the PC and IF/ID (combinational).
- `bubble_count` out W_CNT: number of inserted bubbles.

## Operation
- Register update priority, evaluated each rising edge: reset > ex_flush > ex_hold > load-use bubble > normal load.
- **Reset or flush:** every `ex_*` output, `ex_wr_reg` and `ex_wr_reg2` go to 0, and `ex_valid` goes to 0. Reset also clears `bubble_count`.
- **Hold:** all registers keep their current value. `bubble_count` does not change.
- **Load-use hazard:** `hz = ex_valid & ex_MemRead & (ex_wr_reg2 != 0) & ((id_uses_rs & id_rs == ex_wr_reg2) | (id_uses_rt & id_rt == ex_wr_reg2))`. `ex_wr_reg2` equals the loaded register `rt` for `lw`.
- **Bubble:** when hz is set and there is no flush or hold, the register is cleared exactly as for a flush, and `bubble_count` increments.
- `bubble_count` saturates at all-ones.
- `id_stall = (hz & ~ex_flush) | ex_hold`.
- **Normal load:** all fields are captured from the ID inputs. `ex_valid` takes `id_valid`.
- A captured slot with `id_valid=0` has all enable fields (RegWrite, RegWrite2, MemRead, MemWrite, Branch, PCSrc) forced to 0.
- **Destination resolution at load,** by `id_RegDst`:
  - 00 → rt
  - 01 → rd
  - 10 → 31
  - 11 → rd
- `ex_wr_reg2 = id_rt` always.
- RegDst is consumed here and is not forwarded.

## Timing
- Latency is one cycle from ID inputs to `ex_*` outputs.
- `id_stall` is combinational from the current EX state and the ID inputs. It is asserted in the same cycle the hazard exists.
- A load-use hazard costs exactly one bubble. On the next cycle the load has left EX, so hz deasserts and the held ID instruction loads.
- Flush and hazard in the same cycle: flush wins, no bubble is counted, and `id_stall` stays 0.
- Hold and hazard in the same cycle: hold wins, the register is frozen, and the hazard is re-evaluated after hold releases.
- Reset asserted mid-stall clears the register in one cycle. `id_stall` drops on the following cycle.

## Structure
- Shared definitions header `mips_defs` holds:
  - control field widths;
  - RegDst encodings (RD_RT, RD_RD, RD_RA, RD_DUAL);
  - the constant 31 for $ra.
- Sub-module `hazard_detect`: purely combinational, producing hz from EX state and ID register fields. It is reused later for forwarding-aware variants.
- Everything else is flat inside `id_ex_stage`.

## Test plan
- **Reset:** hold reset for 2 cycles with random inputs. Expect all outputs 0, `id_stall=0`, `bubble_count=0`.
- **Load-use:**
  - Stimulus: `lw $t0`, which loads `ex_MemRead=1`, `ex_wr_reg2=8`; then ID `add` with `id_rs=8`, `id_uses_rs=1`.
  - Expect `id_stall=1` for one cycle, then a bubble (`ex_valid=0`, `ex_RegWrite=0`), `bubble_count=1`, then the `add` loads.
  - Also check `id_rt=0` after `lw $zero`: expect no stall.
- **Flush:** `ex_flush=1` while a hazard is present. Expect the register cleared, `id_stall=0`, `bubble_count` unchanged.
- **Hold:** `ex_hold=1` for 3 cycles while the ID inputs change. Expect `ex_*` frozen and `id_stall=1`. Release and expect the current ID values loaded.
- **Destination resolution:** `id_rt=5`, `id_rd=9`; sweep RegDst 00/01/10/11. Expect `ex_wr_reg` = 5, 9, 31, 9 and `ex_wr_reg2=5`.
- **Saturation:** `W_CNT=3`, force 9 consecutive load-use bubbles. Expect `bubble_count` to stay at 7.
